smc777_vram_arbiter: RTL and testbench
======================================

SMC777_VRAM_ARBITER -- requirements
Module: smc777_vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: VRAM word-address width.
REQ-002 Parameter DATA_W, default 8: VRAM data width.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 vid_req  in  1  single-cycle video fetch request.
REQ-006 vid_addr  in  ADDR_W  video fetch address, valid with vid_req.
REQ-007 vid_data  out  DATA_W  fetched video byte.
REQ-008 vid_valid  out  1  one-cycle strobe marking vid_data valid.
REQ-009 cpu_req  in  1  level CPU VRAM access request, held until cpu_wait_n seen high.
REQ-010 cpu_we  in  1  CPU write (1) / read (0), stable while cpu_req is high.
REQ-011 cpu_addr  in  ADDR_W  CPU address.
REQ-012 cpu_wdata  in  DATA_W  CPU write data.
REQ-013 cpu_rdata  out  DATA_W  CPU read data.
REQ-014 cpu_wait_n  out  1  Z80 wait; low stalls the CPU.
REQ-015 ram_addr  out  ADDR_W  synchronous VRAM address.
REQ-016 ram_we  out  1  VRAM write enable.
REQ-017 ram_wdata  out  DATA_W  VRAM write data.
REQ-018 ram_rdata  in  DATA_W  VRAM read data, valid one cycle after address.

Function
REQ-019 FSM states: IDLE, VID, CPU, CPU_ACK; one VRAM access per cycle.
REQ-020 Grant is evaluated every cycle in IDLE, VID and CPU_ACK; vid_req wins over a pending cpu_req (except as in REQ-033).
REQ-021 VID cycle N: ram_addr=vid_addr, ram_we=0; cycle N+1: vid_data=ram_rdata registered, vid_valid=1 for exactly one cycle.
REQ-022 Back-to-back vid_req are served every cycle with no bubbles.
REQ-023 CPU pending = cpu_req high and not yet served; cpu_wait_n is low combinationally while CPU is pending.
REQ-024 CPU cycle N: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we for exactly one cycle.
REQ-025 CPU_ACK cycle N+1: read data is latched into cpu_rdata and held until the next CPU read; cpu_wait_n=1.
REQ-026 A served flag keeps cpu_wait_n high and blocks re-service until cpu_req drops, so each request is serviced once.
REQ-027 cpu_req falling while pending (aborted cycle) returns the block to no-pending, with no RAM access issued.
REQ-028 vid_req and cpu_req rising in the same cycle: video first; CPU is granted on the first cycle with no vid_req.
REQ-029 A vid_req arriving during the CPU state is not lost: it is registered and served in the next cycle.
REQ-030 ram_we is never high outside the CPU state, and never high for more than one cycle per request.

Reset
REQ-031 Asynchronous reset: state=IDLE; vid_valid=0; vid_data=0; cpu_rdata=0; ram_we=0; ram_addr=0; ram_wdata=0; served flag=0; starvation counter=0; cpu_wait_n=1 while reset is asserted.
REQ-032 Reset asserted mid-access cancels it; no ram_we and no vid_valid strobe occur after reset deasserts for that access.

Configuration
REQ-033 With SMC777_VRAM_STARVE_GUARD_EN defined: a 3-bit counter counts consecutive video grants while the CPU is pending. At STARVE_MAX (4), the next slot goes to the CPU even if vid_req is high; that vid_req is registered per REQ-029. The counter clears on every CPU grant.
REQ-034 Without SMC777_VRAM_STARVE_GUARD_EN: strict video priority, and no counter logic is present.

Structure
REQ-035 Package smc777_pkg holds VRAM_ADDR_W, VRAM_DATA_W, STARVE_MAX and the arbiter state enum typedef.
REQ-036 Single module with no sub-modules; the VRAM is instantiated outside this block.

Verification
REQ-037 Reset, then vid_req with addr 0x0010 and RAM[0x10]=0xA5 -> vid_valid one cycle later with vid_data=0xA5.
REQ-038 CPU write 0x3C to 0x1234 with no video -> cpu_wait_n low one cycle, ram_we high one cycle at 0x1234, then cpu_wait_n high until cpu_req drops.
REQ-039 vid_req and cpu_req (read 0x0001) in the same cycle -> video served in cycle N, CPU in N+1, cpu_rdata valid in N+2.
REQ-040 vid_req continuous for 10 cycles with CPU pending: guard enabled -> CPU granted after 4 video grants; guard disabled -> CPU granted at cycle 10.
REQ-041 Reset asserted in the CPU state during a write -> ram_we=0 immediately, cpu_wait_n=1, no further RAM access.
REQ-042 cpu_req dropped while pending -> no ram_we; the next cpu_req is serviced normally.

Source files
------------

// File: rtl/smc777_pkg.sv
// Shared constants and state encoding for the SMC-777 VRAM arbiter.
package smc777_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;
  localparam int STARVE_MAX  = 4;

  typedef enum logic [1:0] {IDLE, VID, CPU, CPU_ACK} arb_state_e;
endpackage

// File: rtl/smc777_vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority over Z80 access; wait_n stalls the CPU.
// Optional CPU starvation guard enabled by defining SMC777_VRAM_STARVE_GUARD_EN.
module smc777_vram_arbiter
  import smc777_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state_q, state_d;
  logic              served_q, served_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  // Two-deep holding queue for video requests that arrive while the slot is taken.
  logic [ADDR_W-1:0] vq_q [2];
  logic [ADDR_W-1:0] vq_d [2];
  logic [1:0]        vcnt_q, vcnt_d;

  logic              cpu_pend, vid_want, can_grant, force_cpu;
  logic              grant_vid, grant_cpu;
  logic [ADDR_W-1:0] vid_head;

  assign cpu_pend  = cpu_req && !served_q;
  assign vid_want  = vid_req || (vcnt_q != 2'd0);
  assign vid_head  = (vcnt_q != 2'd0) ? vq_q[0] : vid_addr;
  assign can_grant = (state_q != CPU);
  assign grant_vid = can_grant && vid_want && !force_cpu;
  assign grant_cpu = can_grant && cpu_pend && (!vid_want || force_cpu);

`ifdef SMC777_VRAM_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_q, starve_d;

  assign force_cpu = cpu_pend && (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (grant_cpu)
      starve_d = 3'd0;
    else if (grant_vid && cpu_pend && starve_q != STARVE_LIM)
      starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= 3'd0;
    else       starve_q <= starve_d;
  end
`else
  assign force_cpu = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    served_d    = cpu_req && (served_q || grant_cpu);
    cpu_rd_d    = grant_cpu ? !cpu_we : cpu_rd_q;
    vid_valid_d = (state_q == VID);
    ram_addr_d  = ram_addr_q;
    ram_we_d    = grant_cpu && cpu_we;
    ram_wdata_d = ram_wdata_q;
    vq_d        = vq_q;
    vcnt_d      = vcnt_q;

    if (state_q == CPU)    state_d = CPU_ACK;
    else if (grant_vid)    state_d = VID;
    else if (grant_cpu)    state_d = CPU;
    else                   state_d = IDLE;

    if (grant_vid) ram_addr_d = vid_head;
    if (grant_cpu) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
    end

    // Serve the queue head first; a live request not served this cycle is queued.
    if (grant_vid && vcnt_q != 2'd0) begin
      vq_d[0] = vq_q[1];
      vcnt_d  = vcnt_q - 2'd1;
    end
    if (vid_req && !(grant_vid && vcnt_q == 2'd0) && vcnt_d != 2'd2) begin
      vq_d[vcnt_d[0]] = vid_addr;
      vcnt_d          = vcnt_d + 2'd1;
    end

    // RAM data is returned in the cycle after the access and then held.
    vid_data_d  = vid_valid_q ? ram_rdata : vid_data_q;
    cpu_rdata_d = (state_q == CPU_ACK && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      served_q    <= 1'b0;
      cpu_rd_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vq_q[0]     <= '0;
      vq_q[1]     <= '0;
      vcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      served_q    <= served_d;
      cpu_rd_q    <= cpu_rd_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vq_q        <= vq_d;
      vcnt_q      <= vcnt_d;
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_data_d;
  assign cpu_rdata  = cpu_rdata_d;
  assign cpu_wait_n = reset || !cpu_pend;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_smc777_vram_arbiter.sv
// Directed bench for smc777_vram_arbiter with a synchronous-read VRAM model.
module tb_smc777_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait_n;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_pass = 0;

  smc777_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_cnt, vv_cnt, we_cyc, nstrobe, exp_we_cyc;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[14'h0010] = 8'hA5;
    mem[14'h0001] = 8'h77;
    for (int k = 0; k < 10; k++) mem[14'h0040 + k] = 8'(8'hC0 + k);

    // Reset state; wait_n forced high even with a request present
    reset   = 1'b1;
    cpu_req = 1'b1;
    #2;
    chk("rst_wait_n",    cpu_wait_n, 1);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_vid_data",  vid_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ram_we",    ram_we, 0);
    chk("rst_ram_addr",  ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    cpu_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single video fetch
    vid_req = 1'b1; vid_addr = 14'h0010;
    tick();
    vid_req = 1'b0;
    chk("vid_ram_addr", ram_addr, 14'h0010);
    chk("vid_ram_we",   ram_we, 0);
    chk("vid_early",    vid_valid, 0);
    tick();
    chk("vid_valid",    vid_valid, 1);
    chk("vid_data",     vid_data, 8'hA5);
    tick();
    chk("vid_strobe_1", vid_valid, 0);
    chk("vid_data_hold", vid_data, 8'hA5);

    // CPU write, no video traffic
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h3C;
    #1;
    chk("wr_wait_low", cpu_wait_n, 0);
    tick();
    chk("wr_ram_we",    ram_we, 1);
    chk("wr_ram_addr",  ram_addr, 14'h1234);
    chk("wr_ram_wdata", ram_wdata, 8'h3C);
    chk("wr_wait_hi",   cpu_wait_n, 1);
    tick();
    chk("wr_we_once",   ram_we, 0);
    chk("wr_ack_wait",  cpu_wait_n, 1);
    tick();
    chk("wr_served_wait", cpu_wait_n, 1);
    chk("wr_no_reissue",  ram_we, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Simultaneous video and CPU read: video first
    vid_req = 1'b1; vid_addr = 14'h0010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001;
    #1;
    chk("sim_wait_low0", cpu_wait_n, 0);
    tick();
    vid_req = 1'b0;
    #1;
    chk("sim_vid_addr",  ram_addr, 14'h0010);
    chk("sim_wait_low1", cpu_wait_n, 0);
    tick();
    chk("sim_cpu_addr",  ram_addr, 14'h0001);
    chk("sim_cpu_we",    ram_we, 0);
    chk("sim_vid_valid", vid_valid, 1);
    chk("sim_vid_data",  vid_data, 8'hA5);
    tick();
    chk("sim_cpu_rdata", cpu_rdata, 8'h77);
    chk("sim_ack_wait",  cpu_wait_n, 1);
    tick();
    cpu_req = 1'b0;
    tick();
    chk("sim_rdata_hold", cpu_rdata, 8'h77);

    // Aborted CPU request while video holds the slot
    vid_req = 1'b1; vid_addr = 14'h0020;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'hEE;
    tick();
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("abort_wait", cpu_wait_n, 1);
    we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (ram_we) we_cnt++;
      tick();
    end
    chk("abort_no_we", we_cnt, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    tick();
    tick();
    chk("readback", cpu_rdata, 8'h3C);
    cpu_req = 1'b0;
    tick();

    // Continuous video with a pending CPU write
`ifdef SMC777_VRAM_STARVE_GUARD_EN
    exp_we_cyc = 5;
`else
    exp_we_cyc = 11;
`endif
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0300; cpu_wdata = 8'h99;
    we_cnt = 0; we_cyc = -1; nstrobe = 0;
    for (int k = 0; k < 16; k++) begin
      vid_req  = (k < 10);
      vid_addr = 14'(14'h0040 + k);
      #1;
      if (ram_we) begin
        we_cnt++;
        if (we_cyc < 0) we_cyc = k;
      end
      if (vid_valid) begin
        chk("burst_data", vid_data, 8'hC0 + nstrobe);
        nstrobe++;
      end
      if (k == 3) chk("burst_wait_low", cpu_wait_n, 0);
      tick();
    end
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    chk("burst_we_cycle", we_cyc, exp_we_cyc);
    chk("burst_we_count", we_cnt, 1);
    chk("burst_strobes",  nstrobe, 10);
    chk("burst_mem",      mem[14'h0300], 8'h99);
    tick(); tick();

    // Reset during a CPU write cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0400; cpu_wdata = 8'h11;
    tick();
    chk("rstw_pre_we", ram_we, 1);
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("rstw_we_low", ram_we, 0);
    chk("rstw_wait",   cpu_wait_n, 1);
    tick();
    reset = 1'b0;
    we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (ram_we) we_cnt++;
      tick();
    end
    chk("rstw_no_we", we_cnt, 0);
    chk("rstw_mem",   mem[14'h0400], 8'h00);

    // Reset during a video access
    vid_req = 1'b1; vid_addr = 14'h0010;
    tick();
    vid_req = 1'b0;
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    vv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (vid_valid) vv_cnt++;
      tick();
    end
    chk("rstv_no_valid", vv_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
